div4_restoring_seq: RTL and testbench
=====================================

Name: div4_restoring_seq

Overview:
- Multi-cycle unsigned restoring divider; one quotient bit per cycle.
- Each cycle runs one trial subtraction of a WIDTH+1-bit partial remainder minus the divisor, with borrow-in tied to 0.
- That subtraction is the borrow-in subtractor's function, generalised to WIDTH+1 bits.
- Sits downstream of operand registers; feeds result consumers through a valid/ready pair.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (>= 2)

Ports:
CLK  input  1  clock, all state updates on rising edge
ASYNCRESET  input  1  asynchronous reset, active-high
START_VALID  input  1  operands presented
START_READY  output  1  block idle and able to accept operands
DIVIDEND  input  WIDTH  unsigned dividend, sampled on start handshake
DIVISOR  input  WIDTH  unsigned divisor, sampled on start handshake
DONE_VALID  output  1  result available
DONE_READY  input  1  consumer accepts result
Q  output  WIDTH  quotient
R  output  WIDTH  remainder
DIV_BY_ZERO  output  1  result flag, divisor was zero

Behaviour:
- Clock and reset: one clock, CLK. Reset ASYNCRESET is asynchronous and active-high; it takes effect immediately without a clock edge.
- Reset values: state IDLE, Q=0, R=0, DIV_BY_ZERO=0, DONE_VALID=0, step counter=0. START_READY=1 while in IDLE, including during reset.
- Reset mid-operation aborts the operation. No DONE_VALID is produced. The first post-reset handshake computes correctly.
- State IDLE:
  - START_READY=1, DONE_VALID=0.
  - Start handshake = START_VALID & START_READY at a rising edge.
  - On handshake: latch DIVIDEND into a shift register, latch DIVISOR, clear partial remainder P (WIDTH+1 bits) and quotient.
  - If DIVISOR==0, go to DONE with Q=all ones, R=DIVIDEND, DIV_BY_ZERO=1.
  - Otherwise go to RUN with counter=0 and DIV_BY_ZERO=0.
- State RUN, exactly WIDTH cycles:
  - START_READY=0, DONE_VALID=0.
  - Per cycle: S = {P[WIDTH-1:0], dividend MSB}, a WIDTH+1-bit value. D = S - {0,divisor}, computed in WIDTH+1 bits, borrow-in 0.
  - If no borrow out: P=D, shift quotient left with 1. Else: P=S, shift quotient left with 0.
  - Dividend shift register shifts left by 1 each step.
  - After the step with counter==WIDTH-1: Q=quotient, R=P[WIDTH-1:0], go to DONE.
- State DONE:
  - DONE_VALID=1, START_READY=0. START_VALID is ignored.
  - Q, R and DIV_BY_ZERO stay stable until the handshake DONE_VALID & DONE_READY, then go to IDLE.
  - No back-to-back acceptance: at least one IDLE cycle separates operations.
- Latency, measured from the start-handshake edge:
  - Normal operation: DONE_VALID rises after WIDTH+1 edges.
  - Divide-by-zero: DONE_VALID rises after 1 edge.
- Q, R and DIV_BY_ZERO hold the last completed result in IDLE and RUN. They are only meaningful while DONE_VALID=1.
- Invariants:
  - All arithmetic is unsigned.
  - Result satisfies Q*DIVISOR+R == DIVIDEND and R < DIVISOR for every nonzero divisor.
  - No X on outputs after reset.

Test Plan:
- WIDTH=4. DIVIDEND=13, DIVISOR=3, handshake at edge 0 -> DONE_VALID at edge 5, Q=4, R=1, DIV_BY_ZERO=0. Back in IDLE after DONE_READY=1.
- Edge values: 15/1 -> Q=15, R=0. 3/7 -> Q=0, R=3. 15/15 -> Q=1, R=0. 0/5 -> Q=0, R=0. Each has 5-edge latency.
- 5/0 -> DONE_VALID at edge 1, Q=15, R=5, DIV_BY_ZERO=1. The next op 9/2 gives Q=4, R=1, DIV_BY_ZERO=0.
- Backpressure: hold DONE_READY=0 for 3 cycles in DONE, with START_VALID=1 and new operands applied -> outputs stable, START_READY=0, new operands not captured. Release -> IDLE, then captured.
- Assert ASYNCRESET between clock edges at RUN step 2 of 14/4 -> outputs clear immediately, DONE_VALID never rises. A following 14/4 gives Q=3, R=2.
- Randomized sweep of all 256 operand pairs -> Q*DIVISOR+R==DIVIDEND and R<DIVISOR when DIVISOR!=0, DBZ rule otherwise.

Source files
------------

// File: rtl/div4_restoring_seq_if.sv
// Operand/result handshake bundle for the restoring divider.
// The start side carries operands in, the done side carries the
// quotient, remainder and divide-by-zero flag back out.
interface div4_restoring_seq_if #(
    parameter int WIDTH = 4
);
    // Start handshake: operands toward the divider
    logic             START_VALID;
    logic             START_READY;
    logic [WIDTH-1:0] DIVIDEND;
    logic [WIDTH-1:0] DIVISOR;

    // Done handshake: result toward the consumer
    logic             DONE_VALID;
    logic             DONE_READY;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DIV_BY_ZERO;

    // Divider side
    modport slave (
        input  START_VALID,
        input  DIVIDEND,
        input  DIVISOR,
        input  DONE_READY,
        output START_READY,
        output DONE_VALID,
        output Q,
        output R,
        output DIV_BY_ZERO
    );

    // Producer/consumer side
    modport master (
        output START_VALID,
        output DIVIDEND,
        output DIVISOR,
        output DONE_READY,
        input  START_READY,
        input  DONE_VALID,
        input  Q,
        input  R,
        input  DIV_BY_ZERO
    );
endinterface

// File: rtl/div4_restoring_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Each RUN cycle shifts the next dividend bit into a WIDTH+1-bit partial
// remainder, tries to subtract the divisor and keeps the difference only
// when the subtraction does not borrow. A zero divisor skips RUN and
// reports all-ones quotient with the dividend as remainder.
// All outputs come straight from flops so the consumer sees clean values.
module div4_restoring_seq #(
    parameter int WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESET,
    div4_restoring_seq_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // WIDTH+1-bit subtract with borrow-in; the extra top bit of the
    // result is the borrow out, set when b + bin exceeds a.
    function automatic logic [WIDTH+1:0] trial_sub(
        input logic [WIDTH:0] a,
        input logic [WIDTH:0] b,
        input logic           bin
    );
        logic [WIDTH+1:0] ext_a;
        logic [WIDTH+1:0] ext_b;
        logic [WIDTH+1:0] ext_c;
        ext_a = {1'b0, a};
        ext_b = {1'b0, b};
        ext_c = {{(WIDTH+1){1'b0}}, bin};
        return ext_a - ext_b - ext_c;
    endfunction

    // Control state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    // Datapath state
    logic [WIDTH-1:0] r_dividend_sh;
    logic [WIDTH-1:0] w_dividend_nxt;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] w_divisor_nxt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH:0]   w_p_nxt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] w_quot_nxt;

    // Registered result and handshake outputs
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] w_r_nxt;
    logic             r_dbz;
    logic             w_dbz_nxt;
    logic             r_done_valid;
    logic             r_start_ready;

    // One restoring step
    logic [WIDTH:0]   w_s;
    logic [WIDTH+1:0] w_sub;
    logic             w_borrow;
    logic [WIDTH:0]   w_step_p;
    logic [WIDTH-1:0] w_step_quot;

    // Handshakes; the ready/valid flops are only set in their own states
    logic             w_start_hs;
    logic             w_done_hs;

    assign w_start_hs = bus.START_VALID & r_start_ready;
    assign w_done_hs  = bus.DONE_READY  & r_done_valid;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_s         = {r_p[WIDTH-1:0], r_dividend_sh[WIDTH-1]};
        w_sub       = trial_sub(w_s, {1'b0, r_divisor}, 1'b0);
        w_borrow    = w_sub[WIDTH+1];
        if (w_borrow) begin
            w_step_p = w_s;
        end else begin
            w_step_p = w_sub[WIDTH:0];
        end
        w_step_quot = {r_quot[WIDTH-2:0], ~w_borrow};
    end

    // Next-state and next-datapath decode for the IDLE/RUN/DONE sequence
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend_sh;
        w_divisor_nxt  = r_divisor;
        w_p_nxt        = r_p;
        w_quot_nxt     = r_quot;
        w_q_nxt        = r_q;
        w_r_nxt        = r_r;
        w_dbz_nxt      = r_dbz;

        case (r_state)
            ST_IDLE: begin
                if (w_start_hs) begin
                    w_dividend_nxt = bus.DIVIDEND;
                    w_divisor_nxt  = bus.DIVISOR;
                    w_p_nxt        = {(WIDTH+1){1'b0}};
                    w_quot_nxt     = {WIDTH{1'b0}};
                    w_cnt_nxt      = CNT_ZERO;
                    if (bus.DIVISOR == {WIDTH{1'b0}}) begin
                        // No iteration needed; the result is fixed
                        w_q_nxt     = {WIDTH{1'b1}};
                        w_r_nxt     = bus.DIVIDEND;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                w_p_nxt        = w_step_p;
                w_quot_nxt     = w_step_quot;
                w_dividend_nxt = {r_dividend_sh[WIDTH-2:0], 1'b0};
                if (r_cnt == CNT_LAST) begin
                    // Last bit resolved: publish the result
                    w_q_nxt     = w_step_quot;
                    w_r_nxt     = w_step_p[WIDTH-1:0];
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                // Results frozen; new operands wait for the next IDLE
                if (w_done_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State and step counter registers
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Dividend shifter, divisor, partial remainder and quotient registers
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_dividend_sh <= {WIDTH{1'b0}};
            r_divisor     <= {WIDTH{1'b0}};
            r_p           <= {(WIDTH+1){1'b0}};
            r_quot        <= {WIDTH{1'b0}};
        end else begin
            r_dividend_sh <= w_dividend_nxt;
            r_divisor     <= w_divisor_nxt;
            r_p           <= w_p_nxt;
            r_quot        <= w_quot_nxt;
        end
    end

    // Result and handshake output registers, decoded from the next state
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_q           <= {WIDTH{1'b0}};
            r_r           <= {WIDTH{1'b0}};
            r_dbz         <= 1'b0;
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            r_q           <= w_q_nxt;
            r_r           <= w_r_nxt;
            r_dbz         <= w_dbz_nxt;
            r_done_valid  <= (w_state_nxt == ST_DONE);
            r_start_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    assign bus.START_READY = r_start_ready;
    assign bus.DONE_VALID  = r_done_valid;
    assign bus.Q           = r_q;
    assign bus.R           = r_r;
    assign bus.DIV_BY_ZERO = r_dbz;

endmodule

// File: tb/tb_div4_restoring_seq.sv
// Directed bench for the 4-bit restoring divider: reset values, hand-worked
// quotients/remainders with latency, divide-by-zero, backpressure,
// asynchronous reset mid-operation and a full operand sweep.
module tb_div4_restoring_seq;

    localparam int W = 4;

    logic CLK;
    logic ASYNCRESET;

    div4_restoring_seq_if #(.WIDTH(W)) bus ();

    div4_restoring_seq #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .bus        (bus.slave)
    );

    int n_cmp;
    int n_mis;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d);
        check({tag, " start_ready"}, {31'd0, bus.START_READY}, 32'd1);
        bus.DIVIDEND    = n;
        bus.DIVISOR     = d;
        bus.START_VALID = 1'b1;
        tick();
        bus.START_VALID = 1'b0;
    endtask

    // Edges after the handshake edge until DONE_VALID is seen
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (bus.DONE_VALID !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] q,
                             input logic [W-1:0] r, input logic dbz);
        check({tag, " Q"},   {28'd0, bus.Q}, {28'd0, q});
        check({tag, " R"},   {28'd0, bus.R}, {28'd0, r});
        check({tag, " DBZ"}, {31'd0, bus.DIV_BY_ZERO}, {31'd0, dbz});
    endtask

    task automatic ack(input string tag);
        bus.DONE_READY = 1'b1;
        tick();
        bus.DONE_READY = 1'b0;
        check({tag, " idle done_valid"},  {31'd0, bus.DONE_VALID},  32'd0);
        check({tag, " idle start_ready"}, {31'd0, bus.START_READY}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        start_op(tag, n, d);
        wait_done(tag, dbz ? 0 : W);
        check_res(tag, q, r, dbz);
        ack(tag);
    endtask

    initial begin
        n_cmp           = 0;
        n_mis           = 0;
        ASYNCRESET      = 1'b1;
        bus.START_VALID = 1'b0;
        bus.DIVIDEND    = 4'd0;
        bus.DIVISOR     = 4'd0;
        bus.DONE_READY  = 1'b0;

        // Reset values, observed while reset is held
        #2;
        check("rst start_ready", {31'd0, bus.START_READY}, 32'd1);
        check("rst done_valid",  {31'd0, bus.DONE_VALID},  32'd0);
        check_res("rst", 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        tick();

        // Basic and boundary operands (latency 4 edges past the handshake edge)
        run_op("13/3",  4'd13, 4'd3,  4'd4,  4'd1, 1'b0);
        run_op("15/1",  4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
        run_op("3/7",   4'd3,  4'd7,  4'd0,  4'd3, 1'b0);
        run_op("15/15", 4'd15, 4'd15, 4'd1,  4'd0, 1'b0);
        run_op("0/5",   4'd0,  4'd5,  4'd0,  4'd0, 1'b0);

        // Divide by zero, then a normal op must clear the flag
        run_op("5/0",   4'd5,  4'd0,  4'd15, 4'd5, 1'b1);
        run_op("9/2",   4'd9,  4'd2,  4'd4,  4'd1, 1'b0);

        // Backpressure: result held, new operands ignored until after IDLE
        start_op("bp 11/2", 4'd11, 4'd2);
        wait_done("bp 11/2", W);
        bus.DIVIDEND    = 4'd2;
        bus.DIVISOR     = 4'd1;
        bus.START_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_res("bp hold", 4'd5, 4'd1, 1'b0);
            check("bp hold done_valid",  {31'd0, bus.DONE_VALID},  32'd1);
            check("bp hold start_ready", {31'd0, bus.START_READY}, 32'd0);
        end
        bus.DONE_READY = 1'b1;
        tick();
        bus.DONE_READY = 1'b0;
        check("bp idle start_ready", {31'd0, bus.START_READY}, 32'd1);
        check("bp idle done_valid",  {31'd0, bus.DONE_VALID},  32'd0);
        tick();
        bus.START_VALID = 1'b0;
        wait_done("bp 2/1", W);
        check_res("bp 2/1", 4'd2, 4'd0, 1'b0);
        ack("bp 2/1");

        // Asynchronous reset at RUN step 2 of 14/4
        run_op("pre 9/2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
        start_op("abort 14/4", 4'd14, 4'd4);
        tick();
        tick();
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_res("abort", 4'd0, 4'd0, 1'b0);
        check("abort done_valid",  {31'd0, bus.DONE_VALID},  32'd0);
        check("abort start_ready", {31'd0, bus.START_READY}, 32'd1);
        tick();
        #2;
        ASYNCRESET = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (bus.DONE_VALID !== 1'b0) seen = 1'b1;
            end
            check("abort no done_valid", {31'd0, seen}, 32'd0);
        end
        run_op("post 14/4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

        // All 256 operand pairs in a scrambled order
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            logic [3:0] n;
            logic [3:0] d;
            string      tag;
            idx = 8'((i * 167) % 256);
            n   = idx[7:4];
            d   = idx[3:0];
            tag = $sformatf("sweep %0d/%0d", n, d);
            start_op(tag, n, d);
            wait_done(tag, (d == 4'd0) ? 0 : W);
            if (d != 4'd0) begin
                check({tag, " q*d+r"}, (32'(bus.Q) * 32'(d)) + 32'(bus.R), 32'(n));
                check({tag, " r<d"}, {31'd0, (bus.R < d)}, 32'd1);
                check({tag, " dbz"}, {31'd0, bus.DIV_BY_ZERO}, 32'd0);
            end else begin
                check_res(tag, 4'd15, n, 1'b1);
            end
            ack(tag);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
